// File: rtl/arm_pkg.sv
// Shared ARM core definitions: immediate-source encodings, fetch FSM states
// and the instruction-class to immediate-source decode.
package arm_pkg;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_B   = 2'b10;
  localparam logic [1:0] IMM_RSV = 2'b11;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_t;

  // Map instruction bits [27:26] to the extender's immediate-source select.
  function automatic logic [1:0] imm_src_of(input logic [1:0] op);
    logic [1:0] sel;
    case (op)
      2'b00:   sel = IMM_DP;
      2'b01:   sel = IMM_MEM;
      2'b10:   sel = IMM_B;
      default: sel = IMM_RSV;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one request at a time over a
// valid/ready + response handshake, and registers the fetched instruction,
// its address, PC+8 and the decoded immediate-source select.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [31:0] IMemAddr,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRdata,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus8,
  output logic [1:0]  ImmSrc
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic         drop, drop_next;
  logic [31:0]  instr_next, pcf_next, plus8_next;
  logic [1:0]   imm_next;
  logic         valid_next;
  logic [31:0]  target;
  logic         unused_target_bits;

  assign target             = {BranchTarget[31:2], 2'b00};
  assign unused_target_bits = ^BranchTarget[1:0];
  assign IMemReqValid       = (state == FETCH_REQ);
  assign IMemAddr           = pc;

  // State, PC, drop flag and instruction register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH_IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      InstrValid <= 1'b0;
      Instr      <= '0;
      PCF        <= RESET_PC;
      PCPlus8    <= RESET_PC + 32'd8;
      ImmSrc     <= IMM_DP;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      drop       <= drop_next;
      InstrValid <= valid_next;
      Instr      <= instr_next;
      PCF        <= pcf_next;
      PCPlus8    <= plus8_next;
      ImmSrc     <= imm_next;
    end
  end

  // Next-state logic: branch redirect overrides PC, handshake drives state.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    valid_next = InstrValid;
    instr_next = Instr;
    pcf_next   = PCF;
    plus8_next = PCPlus8;
    imm_next   = ImmSrc;

    case (state)
      FETCH_IDLE: state_next = FETCH_REQ;
      FETCH_REQ: begin
        if (IMemReqReady) begin
          state_next = FETCH_WAIT;
          drop_next  = BranchTaken;
        end
      end
      FETCH_WAIT: begin
        if (IMemRspValid) begin
          // A redirect arriving with the response consumes it here, so the
          // flag is cleared rather than carried into the next request.
          if (drop || BranchTaken) begin
            drop_next  = 1'b0;
            state_next = FETCH_REQ;
          end else begin
            instr_next = IMemRdata;
            pcf_next   = pc;
            plus8_next = pc + 32'd8;
            imm_next   = imm_src_of(IMemRdata[27:26]);
            valid_next = 1'b1;
            pc_next    = pc + 32'd4;
            state_next = FETCH_HOLD;
          end
        end else if (BranchTaken) begin
          drop_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (BranchTaken || !Stall) begin
          valid_next = 1'b0;
          state_next = FETCH_REQ;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase

    if (BranchTaken) pc_next = target;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        IMemReqValid;
  logic        IMemReqReady;
  logic [31:0] IMemAddr;
  logic        IMemRspValid;
  logic [31:0] IMemRdata;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Stall;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] PCF;
  logic [31:0] PCPlus8;
  logic [1:0]  ImmSrc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: next expected fetch address and the one outstanding request.
  logic [31:0] exp_pc;
  logic        out_active;
  logic [31:0] out_addr;
  logic        out_dropped;
  logic        mem_pending;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;
  int unsigned lat;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .IMemReqValid (IMemReqValid),
    .IMemReqReady (IMemReqReady),
    .IMemAddr     (IMemAddr),
    .IMemRspValid (IMemRspValid),
    .IMemRdata    (IMemRdata),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Stall        (Stall),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .PCF          (PCF),
    .PCPlus8      (PCPlus8),
    .ImmSrc       (ImmSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_1005;
      32'h0000_0004: return 32'hE591_2004;
      32'h0000_0008: return 32'hEA00_0002;
      default:       return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1234_5678;
    endcase
  endfunction

  task automatic model_reset();
    exp_pc       = 32'h0000_0000;
    out_active   = 1'b0;
    out_dropped  = 1'b0;
    out_addr     = '0;
    mem_pending  = 1'b0;
    mem_cnt      = 0;
    IMemRspValid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  32'(InstrValid),   32'd0);
    check({tag, "_instr"},  Instr,             32'd0);
    check({tag, "_pcf"},    PCF,               32'd0);
    check({tag, "_plus8"},  PCPlus8,           32'd8);
    check({tag, "_imm"},    32'(ImmSrc),       32'd0);
    check({tag, "_reqv"},   32'(IMemReqValid), 32'd0);
    check({tag, "_addr"},   IMemAddr,          32'd0);
  endtask

  // One clock: inputs already set by the caller; checks the edge's effect.
  task automatic step();
    logic        p_valid, p_stall, p_branch, p_reqv, p_ready, p_rspv;
    logic [31:0] p_addr, p_instr, p_pcf, p_plus8, p_rdata, p_tgt;
    logic [1:0]  p_imm;
    p_valid = InstrValid;  p_stall = Stall;     p_branch = BranchTaken;
    p_reqv  = IMemReqValid; p_ready = IMemReqReady; p_rspv = IMemRspValid;
    p_addr  = IMemAddr;    p_instr = Instr;     p_pcf = PCF;
    p_plus8 = PCPlus8;     p_rdata = IMemRdata; p_tgt = BranchTarget;
    p_imm   = ImmSrc;
    @(negedge clk);

    if (p_valid) begin
      if (p_branch) check("flush", 32'(InstrValid), 32'd0);
      else if (p_stall) begin
        check("stall_instr", Instr, p_instr);
        check("stall_pcf", PCF, p_pcf);
        check("stall_plus8", PCPlus8, p_plus8);
        check("stall_imm", 32'(ImmSrc), 32'(p_imm));
        check("stall_valid", 32'(InstrValid), 32'd1);
        check("stall_noreq", 32'(IMemReqValid), 32'd0);
      end else check("consume", 32'(InstrValid), 32'd0);
    end

    if (p_reqv && !p_ready && !p_branch) begin
      check("bp_valid", 32'(IMemReqValid), 32'd1);
      check("bp_addr", IMemAddr, p_addr);
    end

    if (p_reqv && p_ready) begin
      check("acc_addr", p_addr, exp_pc);
      out_active  = 1'b1;
      out_addr    = p_addr;
      out_dropped = p_branch;
      mem_pending = 1'b1;
      mem_addr    = p_addr;
      mem_cnt     = lat;
    end else if (out_active && p_rspv) begin
      out_active = 1'b0;
      if (out_dropped || p_branch) check("drop", 32'(InstrValid), 32'd0);
      else begin
        check("cap_valid", 32'(InstrValid), 32'd1);
        check("cap_instr", Instr, p_rdata);
        check("cap_pcf", PCF, out_addr);
        check("cap_plus8", PCPlus8, out_addr + 32'd8);
        check("cap_imm", 32'(ImmSrc), 32'(p_rdata[27:26]));
        exp_pc = out_addr + 32'd4;
      end
    end else if (out_active && p_branch) out_dropped = 1'b1;

    if (p_branch) exp_pc = {p_tgt[31:2], 2'b00};

    if (mem_pending && mem_cnt == 0) begin
      IMemRspValid = 1'b1;
      IMemRdata    = mem_word(mem_addr);
      mem_pending  = 1'b0;
    end else begin
      IMemRspValid = 1'b0;
      IMemRdata    = $urandom;
      if (mem_pending) mem_cnt--;
    end
  endtask

  task automatic wait_valid();
    int unsigned k = 0;
    do begin step(); k++; end while (!InstrValid && k < 50);
    check("wait_valid", 32'(InstrValid), 32'd1);
  endtask

  task automatic wait_req();
    int unsigned k = 0;
    do begin step(); k++; end while (!IMemReqValid && k < 50);
    check("wait_req", 32'(IMemReqValid), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; IMemReqReady = 1'b1; BranchTaken = 1'b0;
    BranchTarget = '0; Stall = 1'b0; IMemRdata = '0; lat = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;

    // Reset, first fetch and sequential stream.
    step();
    check("first_reqv", 32'(IMemReqValid), 32'd1);
    check("first_addr", IMemAddr, 32'h0);
    wait_valid();
    check("i0_instr", Instr, 32'hE3A0_1005);
    check("i0_pcf", PCF, 32'h0);
    check("i0_plus8", PCPlus8, 32'h8);
    check("i0_imm", 32'(ImmSrc), 32'd0);
    wait_valid();
    check("i1_pcf", PCF, 32'h4);
    check("i1_imm", 32'(ImmSrc), 32'd1);
    wait_valid();
    check("i2_pcf", PCF, 32'h8);
    check("i2_imm", 32'(ImmSrc), 32'd2);

    // Stall in HOLD for three cycles, then release.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    Stall = 1'b0;
    step();
    check("req_after_stall", 32'(IMemReqValid), 32'd1);
    check("addr_after_stall", IMemAddr, 32'hC);

    // Branch while WAIT: in-flight response dropped.
    lat = 2;
    step();
    check("br_in_wait_active", 32'(out_active), 32'd1);
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0103;
    step();
    BranchTaken = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !IMemReqValid; i++) begin
      step();
      check("br_novalid", 32'(InstrValid), 32'd0);
    end
    check("br_reqv", 32'(IMemReqValid), 32'd1);
    check("br_addr", IMemAddr, 32'h0000_0100);

    // Backpressure: address must hold while not accepted.
    IMemReqReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_addr_hold", IMemAddr, 32'h0000_0100);
    end
    IMemReqReady = 1'b1;
    wait_valid();
    check("br_tgt_pcf", PCF, 32'h0000_0100);

    // Branch on the accept cycle: that response is dropped.
    wait_req();
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0200;
    step();
    BranchTaken = 1'b0;
    wait_valid();
    check("acc_br_pcf", PCF, 32'h0000_0200);

    // PC wrap around 2^32.
    BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFE;
    step();
    BranchTaken = 1'b0;
    wait_valid();
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_plus8", PCPlus8, 32'h0000_0004);
    wait_req();
    check("wrap_addr", IMemAddr, 32'h0000_0000);

    // Asynchronous reset pulse while WAIT.
    lat = 3;
    step();
    check("rst_wait_active", 32'(out_active), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    lat = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_rst_addr", IMemAddr, 32'h0);
    wait_valid();
    check("post_rst_pcf", PCF, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      IMemReqReady = ($urandom_range(0, 3) != 0);
      Stall        = ($urandom_range(0, 9) < 3);
      BranchTaken  = ($urandom_range(0, 19) == 0);
      BranchTarget = $urandom;
      lat          = $urandom_range(0, 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end instruction fetch stage for the ARM core. It holds the PC and fetches one instruction at a time from instruction memory over a valid/ready request plus response handshake. It registers the instruction and its PC, and decodes the 2-bit immediate-source select from the instruction class. Its `Instr[23:0]` and `ImmSrc` outputs feed the immediate extender directly, and `PCPlus8` feeds the branch-target adder.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; must be word aligned.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IMemReqValid`  out  1  fetch request valid.
- `IMemReqReady`  in  1  memory accepts request.
- `IMemAddr`  out  32  fetch address (= PC).
- `IMemRspValid`  in  1  read data valid.
- `IMemRdata`  in  32  fetched instruction word.
- `BranchTaken`  in  1  redirect PC this cycle.
- `BranchTarget`  in  32  redirect address; bits [1:0] ignored (forced 00).
- `Stall`  in  1  downstream cannot consume the held instruction.
- `InstrValid`  out  1  `Instr` / `PCF` / `ImmSrc` are valid.
- `Instr`  out  32  instruction register.
- `PCF`  out  32  address of `Instr`.
- `PCPlus8`  out  32  `PCF + 8`, modulo 2^32.
- `ImmSrc`  out  2  00 DP, 01 MEM, 10 B, 11 reserved.

## Operation
- **Reset state:** state IDLE; PC = `RESET_PC`; Drop = 0; `InstrValid` = 0; `Instr` = 0; `PCF` = `RESET_PC`; `ImmSrc` = 00; `IMemReqValid` = 0.
- **States:** IDLE, REQ, WAIT, HOLD. At most one request is outstanding.
- **IDLE:**
  - Goes to REQ after one cycle.
  - If `BranchTaken`, PC <= target.
- **REQ:**
  - Drives `IMemReqValid` = 1 and `IMemAddr` = PC.
  - When `IMemReqReady` = 1, goes to WAIT.
  - `IMemAddr` is held stable until accepted.
- **WAIT:** waits for `IMemRspValid`.
  - Drop = 0: `Instr` <= `IMemRdata`, `PCF` <= PC, PC <= PC + 4, `InstrValid` <= 1, then HOLD.
  - Drop = 1: the data is discarded, Drop <= 0, then REQ.
- **HOLD:**
  - The instruction is consumed on the edge where `InstrValid` = 1 and `Stall` = 0. On that edge, `InstrValid` <= 0 and the state goes to REQ.
  - With `Stall` = 1, all outputs hold.
- **Redirect with `BranchTaken` = 1.** Priority is reset > branch > stall/handshake.
  - PC <= {`BranchTarget`[31:2], 2'b00} in every state.
  - REQ with `IMemReqReady` = 1 on the same cycle: the request is accepted, Drop <= 1, and the state goes to WAIT.
  - REQ with `IMemReqReady` = 0: the state stays REQ, and the new PC is driven next cycle.
  - WAIT: Drop <= 1. If `IMemRspValid` arrives the same cycle, that response is dropped and the state goes to REQ.
  - HOLD: `InstrValid` <= 0 (held instruction flushed, even if `Stall` = 1), then REQ.
- **ImmSrc decode,** registered alongside `Instr` from `IMemRdata`[27:26]:
  - 00 -> 00
  - 01 -> 01
  - 10 -> 10
  - 11 -> 11
- **Arithmetic:** PC + 4 and `PCF` + 8 wrap modulo 2^32; no overflow flag.
- **Reset mid-operation:**
  - Immediate return to reset values.
  - A response for a request issued before reset is ignored, because the unit is in IDLE/REQ with Drop = 0.
  - Memory must not return responses for requests issued before reset.

## Timing
- Registered outputs: `Instr`, `PCF`, `ImmSrc`, `InstrValid`, `PCPlus8`.
- Combinational from state: `IMemReqValid`. `IMemAddr` = PC register.
- Minimum cycles per instruction: 3 (REQ 1, WAIT ≥1, HOLD ≥1), with zero-wait memory and no stall.
- First `IMemReqValid` appears in cycle 1 after `reset_n` deasserts (IDLE occupies cycle 0).
- After capture, `InstrValid` rises the cycle after `IMemRspValid`.
- Redirect latency: the first request to the target is issued ≤1 cycle after `BranchTaken` (REQ/HOLD/IDLE), or after the in-flight response returns (WAIT).

## Structure
- Shared package `arm_pkg`:
  - `ImmSrc` encodings `IMM_DP` = 2'b00, `IMM_MEM` = 2'b01, `IMM_B` = 2'b10, shared with the extender.
  - Fetch state enum.
  - Function `imm_src_of(op[1:0])`.
- Single module; no sub-module. The PC register, FSM, Drop flag and instruction register are all local.

## Test plan
- **Reset:** `RESET_PC` = 0; memory returns 32'hE3A01005 one cycle after accept -> `IMemAddr` = 0, then `Instr` = E3A01005, `ImmSrc` = 00, `PCF` = 0, `PCPlus8` = 8, `InstrValid` = 1.
- **Sequential stream:** E5912004 then EA000002 -> `ImmSrc` 01 at `PCF` = 4, then 10 at `PCF` = 8; `IMemAddr` sequence 0, 4, 8, 12.
- **Stall:** `Stall` = 1 for 3 cycles in HOLD -> outputs stable, no new request. Release -> next `IMemReqValid` the following cycle.
- **Branch in WAIT:** `BranchTaken` with target 32'h0000_0103 -> the in-flight response is not captured (`InstrValid` stays 0), and the next `IMemAddr` = 32'h0000_0100.
- **Backpressure:** `IMemReqReady` low for 4 cycles -> `IMemAddr` stable.
- **Simultaneous events:** `BranchTaken` on the same cycle as accept -> that response is dropped.
- **Mid-flight reset and wrap:** PC = 32'hFFFF_FFFC fetch -> `PCF` = FFFF_FFFC, `PCPlus8` = 4, next `IMemAddr` = 0. Asynchronous `reset_n` pulse in WAIT -> all outputs return to reset values immediately.
